// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
//   Groups the three buses around the instruction/data memory arbiter: the
//   instruction requester, the data requester and the shared memory port.
//
//   modport slave  : the arbiter's view. It serves the two requesters and
//                    drives the memory port.
//   modport master : the environment's view. It drives the requests and
//                    answers on the memory port.
//
//   Instruction side : i_req, i_addr            -> i_rdata, i_ack, i_err
//   Data side        : d_req, d_we, d_addr,
//                      d_wdata                  -> d_rdata, d_ack, d_err
//   Memory side      : m_req, m_we, m_addr,
//                      m_wdata                  <- m_rdata, m_ready
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if;
  // Instruction side
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        i_err;
  // Data side
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        d_err;
  // Memory side
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ready;

  modport slave (
    input  i_req, i_addr,
    output i_rdata, i_ack, i_err,
    input  d_req, d_we, d_addr, d_wdata,
    output d_rdata, d_ack, d_err,
    output m_req, m_we, m_addr, m_wdata,
    input  m_rdata, m_ready
  );

  modport master (
    output i_req, i_addr,
    input  i_rdata, i_ack, i_err,
    output d_req, d_we, d_addr, d_wdata,
    input  d_rdata, d_ack, d_err,
    input  m_req, m_we, m_addr, m_wdata,
    output m_rdata, m_ready
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one memory port between an instruction requester and a data
//   requester. One transaction at a time walks IDLE -> ACCESS -> RESP.
//   Simultaneous requests alternate, starting with the instruction side after
//   reset. ACCESS waits up to MAX_WAIT cycles for m_ready before it gives up
//   and reports an error to the granted side.
//
// Parameters
//   MAX_WAIT : ACCESS cycles allowed for m_ready before timeout (1..255).
//
// Ports
//   clk  : single clock, all state changes on the rising edge
//   rst  : synchronous active-low reset
//   bus  : requester and memory buses (slave modport of mem_port_arbiter_if)
//   busy : high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus,
  output logic                busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  typedef enum logic {
    SIDE_INSTR = 1'b0,
    SIDE_DATA  = 1'b1
  } side_e;

  localparam int unsigned      CW       = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0]    CNT_LAST = CW'(MAX_WAIT - 1);
  localparam logic [CW-1:0]    CNT_MAX  = CW'(MAX_WAIT);

  state_e        state_q,      state_d;
  side_e         gnt_q,        gnt_d;
  side_e         last_grant_q, last_grant_d;
  logic [31:0]   addr_q,       addr_d;
  logic          we_q,         we_d;
  logic [31:0]   wdata_q,      wdata_d;
  logic [CW-1:0] cnt_q,        cnt_d;
  logic          err_q,        err_d;
  logic [31:0]   i_rdata_q,    i_rdata_d;
  logic [31:0]   d_rdata_q,    d_rdata_d;

  // Data wins in IDLE when it asks alone, or when both ask and instruction
  // had the previous turn.
  logic grant_data;
  assign grant_data = bus.d_req && (!bus.i_req || (last_grant_q == SIDE_INSTR));

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves one unassigned; a missing default would infer a latch.
    state_d      = state_q;
    gnt_d        = gnt_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.i_req || bus.d_req) begin
          state_d = S_ACCESS;
          cnt_d   = '0;
          err_d   = 1'b0;
          if (grant_data) begin
            gnt_d   = SIDE_DATA;
            addr_d  = bus.d_addr;
            we_d    = bus.d_we;
            wdata_d = bus.d_wdata;
          end else begin
            // Instruction fetches never write.
            gnt_d   = SIDE_INSTR;
            addr_d  = bus.i_addr;
            we_d    = 1'b0;
            wdata_d = '0;
          end
        end
      end

      S_ACCESS: begin
        if (bus.m_ready) begin
          // Ready takes priority even on the last allowed cycle.
          state_d = S_RESP;
          err_d   = 1'b0;
          if (!we_q) begin
            if (gnt_q == SIDE_DATA) d_rdata_d = bus.m_rdata;
            else                    i_rdata_d = bus.m_rdata;
          end
        end else begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
          // cnt_q counts earlier unanswered cycles, so this is the MAX_WAIT-th.
          if (cnt_q == CNT_LAST) begin
            state_d = S_RESP;
            err_d   = 1'b1;
          end
        end
      end

      S_RESP: begin
        last_grant_d = gnt_q;
        state_d      = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst) begin
      state_q      <= S_IDLE;
      gnt_q        <= SIDE_INSTR;
      last_grant_q <= SIDE_DATA;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all decoded from registered state, so a reset edge silences
  // m_req and any pending ack/err immediately.
  // ---------------------------------------------------------------------------
  logic in_access, in_resp;
  assign in_access = (state_q == S_ACCESS);
  assign in_resp   = (state_q == S_RESP);

  assign bus.m_req   = in_access;
  assign bus.m_we    = in_access && we_q;
  assign bus.m_addr  = addr_q;
  assign bus.m_wdata = wdata_q;

  assign bus.i_ack   = in_resp && (gnt_q == SIDE_INSTR) && !err_q;
  assign bus.i_err   = in_resp && (gnt_q == SIDE_INSTR) &&  err_q;
  assign bus.d_ack   = in_resp && (gnt_q == SIDE_DATA)  && !err_q;
  assign bus.d_err   = in_resp && (gnt_q == SIDE_DATA)  &&  err_q;

  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;

  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Self-checking bench for mem_port_arbiter. Each transaction is described by
//   a txn_t record: the request, how the memory should answer, and the
//   expected outcome. Records are pushed to exp_q when the request is driven.
//   A memory responder/monitor process answers from the head record and pops
//   it when ack/err appears.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int MAX_WAIT = 15;

  typedef struct {
    logic        side;       // 0 = instruction, 1 = data
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ready_at;   // ACCESS cycle (1-based) with m_ready=1; 0 = never
    logic [31:0] mem_rdata;
    logic        exp_err;
    logic [31:0] exp_rdata;  // expected rdata of the granted side at ack/err
  } txn_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int   checks   = 0;
  int   errors   = 0;
  int   resp_cnt = 0;
  int   acc      = 0;
  int   last_burst = 0;
  txn_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic txn_t mk(input logic side, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input int ready_at,
                              input logic [31:0] mem_rdata, input logic exp_err,
                              input logic [31:0] exp_rdata);
    txn_t t;
    t.side      = side;
    t.we        = we;
    t.addr      = addr;
    t.wdata     = wdata;
    t.ready_at  = ready_at;
    t.mem_rdata = mem_rdata;
    t.exp_err   = exp_err;
    t.exp_rdata = exp_rdata;
    return t;
  endfunction

  function automatic int burst_len(input txn_t t);
    return (t.ready_at == 0) ? MAX_WAIT : t.ready_at;
  endfunction

  // ---------------------------------------------------------------------------
  // Memory responder and response monitor (acts on falling edges)
  // ---------------------------------------------------------------------------
  initial begin : mem_and_monitor
    logic [3:0] flags;
    logic [3:0] exp_flags;
    txn_t       e;
    bus.m_ready = 1'b0;
    bus.m_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.m_req) begin
        acc++;
        if (exp_q.size() > 0) begin
          check("m_addr", bus.m_addr, exp_q[0].addr);
          check("m_we", 32'(bus.m_we), 32'(exp_q[0].we));
          if (exp_q[0].we) check("m_wdata", bus.m_wdata, exp_q[0].wdata);
          bus.m_ready = (exp_q[0].ready_at == acc);
          bus.m_rdata = bus.m_ready ? exp_q[0].mem_rdata : $urandom;
        end else begin
          bus.m_ready = 1'b0;
          bus.m_rdata = $urandom;
        end
      end else begin
        if (acc != 0) last_burst = acc;
        acc = 0;
        // Noise outside ACCESS must be ignored by the arbiter.
        bus.m_ready = 1'($urandom_range(0, 1));
        bus.m_rdata = $urandom;
      end

      flags = {bus.i_ack, bus.i_err, bus.d_ack, bus.d_err};
      if (flags != 4'b0000) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: flags %b with nothing pending", flags);
        end else begin
          e = exp_q.pop_front();
          exp_flags = e.side ? {2'b00, !e.exp_err, e.exp_err}
                             : {!e.exp_err, e.exp_err, 2'b00};
          check("resp_flags", 32'(flags), 32'(exp_flags));
          check("rdata", e.side ? bus.d_rdata : bus.i_rdata, e.exp_rdata);
          check("m_req_cycles", last_burst, burst_len(e));
          check("busy_resp", 32'(busy), 32'd1);
          resp_cnt++;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver helpers (act 1 time unit after the falling edge)
  // ---------------------------------------------------------------------------
  task automatic wait_resp(input int target, input int budget, output int cycles);
    cycles = 0;
    while (resp_cnt < target && cycles < budget) begin
      @(negedge clk); #1;
      cycles++;
    end
    if (resp_cnt < target) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout: got %0d responses expected %0d", resp_cnt, target);
    end
  endtask

  task automatic idle_after_resp();
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    @(negedge clk); #1;
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic run_txn(input txn_t t);
    int start;
    int k;
    start = resp_cnt;
    if (t.side) begin
      bus.d_req   = 1'b1;
      bus.d_we    = t.we;
      bus.d_addr  = t.addr;
      bus.d_wdata = t.wdata;
    end else begin
      bus.i_req   = 1'b1;
      bus.i_addr  = t.addr;
    end
    exp_q.push_back(t);
    wait_resp(start + 1, 64, k);
    check("latency", k, burst_len(t) + 1);
    idle_after_resp();
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  txn_t vecs[8];

  initial begin : main
    int start;
    int k;

    // Requests in table order; expected rdata follows the history.
    vecs[0] = mk(0, 0, 32'h0040_0000, 32'h0,         1, 32'h0050_0113, 0, 32'h0050_0113);
    vecs[1] = mk(1, 1, 32'h0000_0010, 32'hDEAD_BEEF, 3, 32'h9999_9999, 0, 32'h4444_4444);
    vecs[2] = mk(0, 0, 32'h0040_0004, 32'h0,         4, 32'h00A0_0093, 0, 32'h00A0_0093);
    vecs[3] = mk(1, 0, 32'h0000_0020, 32'h0,         2, 32'hCAFE_F00D, 0, 32'hCAFE_F00D);
    vecs[4] = mk(1, 1, 32'h0000_0024, 32'h1234_5678, 1, 32'h8888_8888, 0, 32'hCAFE_F00D);
    vecs[5] = mk(1, 0, 32'h0000_0028, 32'h0,         0, 32'hBADB_AD00, 1, 32'hCAFE_F00D);
    vecs[6] = mk(1, 0, 32'h0000_002C, 32'h0,  MAX_WAIT, 32'h0F0F_0F0F, 0, 32'h0F0F_0F0F);
    vecs[7] = mk(0, 0, 32'h0040_0008, 32'h0,         0, 32'hBADB_AD01, 1, 32'h00A0_0093);

    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;

    // Reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_m_req",   32'(bus.m_req), 32'd0);
    check("rst_m_we",    32'(bus.m_we),  32'd0);
    check("rst_m_addr",  bus.m_addr,     32'd0);
    check("rst_m_wdata", bus.m_wdata,    32'd0);
    check("rst_flags",   32'({bus.i_ack, bus.i_err, bus.d_ack, bus.d_err}), 32'd0);
    check("rst_busy",    32'(busy),      32'd0);
    check("rst_i_rdata", bus.i_rdata,    32'd0);
    check("rst_d_rdata", bus.d_rdata,    32'd0);
    rst = 1'b1;
    @(negedge clk); #1;

    // Tie alternation straight after reset: INSTR, DATA, INSTR, DATA
    start = resp_cnt;
    bus.i_req = 1'b1; bus.i_addr = 32'h0040_0100;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_0200; bus.d_wdata = '0;
    exp_q.push_back(mk(0, 0, 32'h0040_0100, 32'h0, 1, 32'h1111_1111, 0, 32'h1111_1111));
    exp_q.push_back(mk(1, 0, 32'h0000_0200, 32'h0, 1, 32'h2222_2222, 0, 32'h2222_2222));
    exp_q.push_back(mk(0, 0, 32'h0040_0100, 32'h0, 1, 32'h3333_3333, 0, 32'h3333_3333));
    exp_q.push_back(mk(1, 0, 32'h0000_0200, 32'h0, 1, 32'h4444_4444, 0, 32'h4444_4444));
    wait_resp(start + 4, 64, k);
    check("tie_cycles", k, 11);
    idle_after_resp();

    // Table-driven single transactions
    for (int i = 0; i < 8; i++) run_txn(vecs[i]);

    // Reset in the 2nd ACCESS cycle of a data read (last grant was INSTR)
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_0300;
    @(negedge clk); #1;
    check("abort_m_req_before", 32'(bus.m_req), 32'd1);
    @(negedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    check("abort_m_req",   32'(bus.m_req), 32'd0);
    check("abort_busy",    32'(busy),      32'd0);
    check("abort_i_rdata", bus.i_rdata,    32'd0);
    check("abort_d_rdata", bus.d_rdata,    32'd0);
    bus.i_req = 1'b1; bus.i_addr = 32'h0040_0300;
    @(negedge clk); #1;
    check("abort_hold_m_req", 32'(bus.m_req), 32'd0);

    // Release reset with both requests high: INSTR must win
    start = resp_cnt;
    exp_q.push_back(mk(0, 0, 32'h0040_0300, 32'h0, 1, 32'h6666_6666, 0, 32'h6666_6666));
    rst = 1'b1;
    wait_resp(start + 1, 64, k);
    check("post_rst_latency", k, 2);
    idle_after_resp();

    // Data read after reset fills d_rdata from zero
    run_txn(mk(1, 0, 32'h0000_0040, 32'h0, 2, 32'h7777_7777, 0, 32'h7777_7777));

    repeat (3) @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15: number of ACCESS cycles allowed for m_ready before timeout; legal range 1..255.
REQ-002 SHALL have ports clk in 1 (single clock, all logic on rising edge) and rst in 1 (synchronous, active-low reset).
REQ-003 SHALL have instruction-side ports: i_req in 1, i_addr in 32, i_rdata out 32, i_ack out 1, i_err out 1.
REQ-004 SHALL have data-side ports: d_req in 1, d_we in 1, d_addr in 32, d_wdata in 32, d_rdata out 32, d_ack out 1, d_err out 1.
REQ-005 SHALL have memory-side ports: m_req out 1, m_we out 1, m_addr out 32, m_wdata out 32, m_rdata in 32, m_ready in 1.
REQ-006 SHALL have port busy out 1: high whenever the FSM is not in IDLE.

Function
REQ-007 SHALL implement a three-state FSM: IDLE, ACCESS, RESP; state is registered.
REQ-008 IDLE, no request: SHALL stay in IDLE with m_req=0.
REQ-009 IDLE, exactly one of i_req/d_req high: SHALL grant that requester and go to ACCESS on the next edge.
REQ-010 IDLE, both high: SHALL grant the requester opposite to last_grant; last_grant resets to DATA, so INSTR wins the first tie.
REQ-011 On grant: SHALL latch address and we/wdata into internal registers (we forced 0 for INSTR).
- Requester inputs are ignored until the next IDLE.
REQ-012 ACCESS: SHALL drive m_req=1, with m_addr/m_we/m_wdata taken from the latched registers.
REQ-013 Outside ACCESS: m_req and m_we SHALL be 0.
REQ-014 Wait counter SHALL clear on grant and increment each ACCESS cycle without m_ready.
- Width: clog2(MAX_WAIT+1) bits; SHALL never wrap.
REQ-015 ACCESS with m_ready=1: SHALL go to RESP with success.
- On a read, SHALL capture m_rdata into the granted side's rdata register.
- This holds even on the MAX_WAIT-th cycle: ready wins over timeout.
REQ-016 ACCESS: if MAX_WAIT cycles have elapsed without m_ready, SHALL go to RESP with error and SHALL NOT update rdata.
REQ-017 m_rdata SHALL be ignored whenever m_ready=0 or the FSM is not in ACCESS; m_ready outside ACCESS SHALL have no effect.
REQ-018 RESP: SHALL pulse exactly one of ack/err for exactly one cycle, on the granted side only.
- SHALL update last_grant to the granted side.
- SHALL return to IDLE on the next edge.
REQ-019 i_rdata/d_rdata SHALL be registered, valid in the ack cycle, and held until the next successful read on that side.
- Writes SHALL leave d_rdata unchanged.
REQ-020 Requester protocol:
- Hold req and its request fields stable until ack/err.
- Drop req in the cycle after ack/err; a req still high in IDLE starts a new transaction.
REQ-021 Deasserting req during ACCESS/RESP SHALL NOT abort the transaction; ack/err is still issued.
REQ-022 Minimum latency: req high in IDLE (cycle 0), m_req in cycle 1, m_ready in cycle 1, ack in cycle 2, i.e. 3 cycles per transaction.

Reset
REQ-023 When rst=0 at a clock edge, the block SHALL, on that edge:
- go to IDLE and set last_grant=DATA;
- clear the counter;
- set m_req=m_we=0, m_addr=m_wdata=0, all ack/err=0, busy=0, i_rdata=d_rdata=0.
REQ-024 Reset during ACCESS or RESP SHALL abort the transaction: no ack/err SHALL be produced for it, and m_req SHALL be low from the first reset cycle.

Verification
REQ-025 Single INSTR read: i_req=1, i_addr=0x00400000; m_ready=1 in the first ACCESS cycle with m_rdata=0x00500113.
- Required: m_addr=0x00400000, m_we=0; i_ack for one cycle with i_rdata=0x00500113; d_ack/d_err stay 0.
REQ-026 Data write with 3-cycle wait: d_req=1, d_we=1, d_addr=0x10, d_wdata=0xDEADBEEF; m_ready high on the 3rd ACCESS cycle.
- Required: m_req high for 3 cycles with m_we=1 and m_wdata=0xDEADBEEF; then one-cycle d_ack; d_rdata unchanged.
REQ-027 Tie alternation: i_req and d_req both held high after reset across 4 transactions.
- Required: grant order INSTR, DATA, INSTR, DATA; each ack appears only on the granted side.
REQ-028 Timeout, MAX_WAIT=15: d_req read with m_ready held 0.
- Required: m_req high for exactly 15 cycles, then one-cycle d_err, no d_ack, d_rdata unchanged, return to IDLE.
- Repeat with m_ready=1 on cycle 15: required d_ack, not d_err.
REQ-029 Reset mid-ACCESS: rst=0 on the 2nd ACCESS cycle.
- Required: m_req=0 and busy=0 from that edge; no ack/err; rdata=0.
- After rst=1 with both requests high: INSTR is granted first.
